// File: rtl/my_lsu_pkg.sv
// Shared constants, state type and request screening for the load/store unit.
package my_lsu_pkg;

  // RV32I funct3 width codes (loads and stores share encodings)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned MAX_WAIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  // True when the op must complete with an error and never touch the bus:
  // an unsupported width code or an address not aligned to the access size.
  function automatic logic op_fault(input logic we, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic illegal;
    logic misal;
    if (we) illegal = (f3 > F3_SW);
    else    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    misal = ((f3[1:0] == 2'b01) && a[0]) ||
            ((f3[1:0] == 2'b10) && (a != 2'b00));
    return illegal | misal;
  endfunction

endpackage

// File: rtl/my_lsu_align.sv
// Byte-lane steering: store byte enables / replicated data, and load
// extraction with sign or zero extension.
module my_lsu_align
  import my_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // Store lanes: replicate the datum across the word, enable only its bytes.
  always_comb begin
    be         = '1;
    wdata_lane = '0;
    if (we) begin
      case (funct3)
        F3_SB: begin
          be         = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        F3_SH: begin
          be         = 4'b0011 << addr_lo;
          wdata_lane = {2{wdata[15:0]}};
        end
        default: begin
          be         = '1;
          wdata_lane = wdata;
        end
      endcase
    end
  end

  // Load extract: bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   rdata_ext = shifted;
      F3_LBU:  rdata_ext = {24'h0, shifted[7:0]};
      F3_LHU:  rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/my_lsu.sv
// Load/store unit: one data-memory transaction per accepted op over a
// req/gnt/rvalid bus, with registered response and load timeout.
module my_lsu
  import my_lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        busy
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] rdata_ext;

  my_lsu_align u_align (
    .we         (we_q),
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata_lane (dmem_wdata),
    .rdata_ext  (rdata_ext)
  );

  // Next-state, request latch, timeout count and response computation.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (op_fault(req_we, req_funct3, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          if (we_q) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = rdata_ext;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset wins from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign dmem_req   = (state_q == ST_REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_my_lsu.sv
// Directed bench for my_lsu: stores, loads, alignment errors, timeout, reset.
module tb_my_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  my_lsu #(.MAX_WAIT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_be     (dmem_be),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  // Store with gnt held high: REQ one cycle after accept, RESP two after.
  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
    dmem_gnt = 1'b1;
    present(1'b1, f3, a, d);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk({tag, "_we"}, 32'(dmem_we), 32'd1);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    chk({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
    chk({tag, "_wdata"}, dmem_wdata, exp_wd);
    chk({tag, "_early_valid"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
  endtask

  // Load with gnt and rvalid immediate: response three cycles after accept.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] word, input logic [31:0] exp_addr,
                          input logic [31:0] exp_rd);
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = word;
    present(1'b0, f3, a, 32'h0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk({tag, "_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_be"}, 32'(dmem_be), 32'hF);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    @(negedge clk);
    chk({tag, "_wait_valid"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    dmem_rvalid = 1'b0;
  endtask

  // Faulting op: no bus request, error response on the next cycle.
  task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a);
    dmem_gnt = 1'b1;
    present(we, f3, a, 32'hFFFF_FFFF);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_noreq"}, 32'(dmem_req), 32'd0);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_err"}, 32'(resp_err), 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    @(negedge clk);
    chk({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int  wait_cycles;
    bit  got;

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_funct3  = 3'b000;
    req_addr    = '0;
    req_wdata   = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Stores
    run_store("sw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    run_store("sb", 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    run_store("sh", 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0000_0100, 4'b1100, 32'h1234_1234);
    run_store("sb1", 3'b000, 32'h0000_0101, 32'h0000_0077, 32'h0000_0100, 4'b0010, 32'h7777_7777);

    // Loads
    run_load("lb", 3'b000, 32'h0000_0201, 32'h0000_80FF, 32'h0000_0200, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 32'h0000_0201, 32'h0000_80FF, 32'h0000_0200, 32'h0000_0080);
    run_load("lhu", 3'b101, 32'h0000_0202, 32'hBEEF_0000, 32'h0000_0200, 32'h0000_BEEF);
    run_load("lh", 3'b001, 32'h0000_0202, 32'hBEEF_0000, 32'h0000_0200, 32'hFFFF_BEEF);

    // Misaligned and illegal
    run_err("lw_mis", 1'b0, 3'b010, 32'h0000_0206);
    run_err("lh_mis", 1'b0, 3'b001, 32'h0000_0201);
    run_err("sw_mis", 1'b1, 3'b010, 32'h0000_0102);
    run_err("ld_ill", 1'b0, 3'b011, 32'h0000_0000);
    run_err("st_ill", 1'b1, 3'b100, 32'h0000_0000);

    // Delayed gnt, no rvalid: timeout after 16 WAIT cycles
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    present(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("to_req1", 32'(dmem_req), 32'd1);
    @(negedge clk);
    chk("to_req2", 32'(dmem_req), 32'd1);
    @(negedge clk);
    chk("to_req3", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    wait_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      if (resp_valid) got = 1'b1;
      else wait_cycles++;
    end
    chk("to_resp_seen", 32'(got), 32'd1);
    chk("to_wait_cycles", 32'(wait_cycles), 32'd16);
    chk("to_err", 32'(resp_err), 32'd1);
    chk("to_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    chk("to_ready", 32'(req_ready), 32'd1);

    // Reset in WAIT, then a stale rvalid
    dmem_gnt = 1'b1;
    present(1'b0, 3'b010, 32'h0000_0400, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    chk("rw_in_wait", 32'(busy & ~dmem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    chk("rw_idle_ready", 32'(req_ready), 32'd1);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_no_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("rw_no_valid2", 32'(resp_valid), 32'd0);
    chk("rw_rdata", resp_rdata, 32'd0);
    run_load("lw0", 3'b010, 32'h0000_0000, 32'h1122_3344, 32'h0000_0000, 32'h1122_3344);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
